// File: rtl/cc_reorder_issue_ctrl_if.sv
// Signal bundle between the reorder issue sequencer and its lookup, flag/data FIFO, AXI AR and R-observe neighbours.
// Defining CC_ISSUE_PERF_CNT_EN adds the performance counter outputs.
interface cc_reorder_issue_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic                  lookup_valid_i;
  logic                  lookup_ready_o;
  logic                  lookup_hit_i;
  logic [ADDR_WIDTH-1:0] lookup_addr_i;
  logic [511:0]          lookup_data_i;
  logic                  hit_flag_fifo_afull_i;
  logic                  hit_flag_fifo_wren_o;
  logic                  hit_flag_fifo_wdata_o;
  logic                  hit_data_fifo_afull_i;
  logic                  hit_data_fifo_wren_o;
  logic [517:0]          hit_data_fifo_wdata_o;
  logic                  mem_arvalid_o;
  logic                  mem_arready_i;
  logic [ADDR_WIDTH-1:0] mem_araddr_o;
  logic [3:0]            mem_arlen_o;
  logic [2:0]            mem_arsize_o;
  logic [1:0]            mem_arburst_o;
  logic                  mem_rvalid_i;
  logic                  mem_rready_i;
  logic                  mem_rlast_i;
  logic [CNT_WIDTH-1:0]  outstanding_o;
  logic                  err_o;
`ifdef CC_ISSUE_PERF_CNT_EN
  logic [31:0]           perf_hit_cnt_o;
  logic [31:0]           perf_miss_cnt_o;
  logic [31:0]           perf_stall_cnt_o;
`endif

  modport master (
    input  lookup_valid_i, lookup_hit_i, lookup_addr_i, lookup_data_i,
           hit_flag_fifo_afull_i, hit_data_fifo_afull_i, mem_arready_i,
           mem_rvalid_i, mem_rready_i, mem_rlast_i,
    output lookup_ready_o, hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o,
           hit_data_fifo_wren_o, hit_data_fifo_wdata_o, mem_arvalid_o,
           mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
           outstanding_o, err_o
`ifdef CC_ISSUE_PERF_CNT_EN
    , output perf_hit_cnt_o, perf_miss_cnt_o, perf_stall_cnt_o
`endif
  );

  modport slave (
    output lookup_valid_i, lookup_hit_i, lookup_addr_i, lookup_data_i,
           hit_flag_fifo_afull_i, hit_data_fifo_afull_i, mem_arready_i,
           mem_rvalid_i, mem_rready_i, mem_rlast_i,
    input  lookup_ready_o, hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o,
           hit_data_fifo_wren_o, hit_data_fifo_wdata_o, mem_arvalid_o,
           mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
           outstanding_o, err_o
`ifdef CC_ISSUE_PERF_CNT_EN
    , input perf_hit_cnt_o, perf_miss_cnt_o, perf_stall_cnt_o
`endif
  );
endinterface

// File: rtl/cc_reorder_issue_ctrl.sv
// Issue sequencer ahead of the reorder unit: writes one hit/miss flag per lookup, pushes hit data, issues AR wrap bursts for misses.
// Optional macro CC_ISSUE_PERF_CNT_EN adds hit/miss/stall performance counters.
module cc_reorder_issue_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int CNT_WIDTH       = 4
) (
  input logic                     clk,
  input logic                     rst,
  cc_reorder_issue_ctrl_if.master bus
);
  typedef enum logic {IDLE = 1'b0, AR_WAIT = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_reg, state_next;
  logic                  lookup_ready;
  logic                  accept_hit, accept_miss, retire;
  logic                  flag_wren_reg, flag_wdata_reg, data_wren_reg;
  logic [517:0]          data_wdata_reg;
  logic [ADDR_WIDTH-1:0] araddr_reg;
  logic [CNT_WIDTH-1:0]  outstanding_reg, outstanding_next;
  logic                  err_reg, err_next;

  assign accept_hit  = bus.lookup_valid_i & lookup_ready & bus.lookup_hit_i;
  assign accept_miss = bus.lookup_valid_i & lookup_ready & ~bus.lookup_hit_i;
  assign retire      = bus.mem_rvalid_i & bus.mem_rready_i & bus.mem_rlast_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept_miss) state_next = AR_WAIT;
      AR_WAIT: if (bus.mem_arready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // arvalid is the AR_WAIT state itself, so an async reset drops it at once.
  always_comb begin
    lookup_ready = (state_reg == IDLE) & ~bus.hit_flag_fifo_afull_i &
                   ~bus.hit_data_fifo_afull_i & (outstanding_reg < MAX_CNT);
    bus.lookup_ready_o        = lookup_ready;
    bus.mem_arvalid_o         = (state_reg == AR_WAIT);
    bus.mem_araddr_o          = araddr_reg;
    bus.mem_arlen_o           = 4'd7;
    bus.mem_arsize_o          = 3'd3;
    bus.mem_arburst_o         = 2'b10;
    bus.hit_flag_fifo_wren_o  = flag_wren_reg;
    bus.hit_flag_fifo_wdata_o = flag_wdata_reg;
    bus.hit_data_fifo_wren_o  = data_wren_reg;
    bus.hit_data_fifo_wdata_o = data_wdata_reg;
    bus.outstanding_o         = outstanding_reg;
    bus.err_o                 = err_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_wren_reg  <= 1'b0;
      flag_wdata_reg <= 1'b0;
      data_wren_reg  <= 1'b0;
      data_wdata_reg <= '0;
      araddr_reg     <= '0;
    end else begin
      flag_wren_reg  <= accept_hit | accept_miss;
      flag_wdata_reg <= accept_hit;
      data_wren_reg  <= accept_hit;
      if (accept_hit)
        data_wdata_reg <= {bus.lookup_addr_i[5:0], bus.lookup_data_i};
      // Critical word first: align to the 8-byte beat inside the wrap burst.
      if (accept_miss)
        araddr_reg <= {bus.lookup_addr_i[ADDR_WIDTH-1:3], 3'b000};
    end
  end

  // A retire with nothing in flight is a protocol error; the count never underflows.
  always_comb begin
    outstanding_next = outstanding_reg;
    err_next         = err_reg | (retire & (outstanding_reg == '0));
    if (accept_miss & ~retire)
      outstanding_next = outstanding_reg + CNT_ONE;
    else if (~accept_miss & retire & (outstanding_reg != '0))
      outstanding_next = outstanding_reg - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

`ifdef CC_ISSUE_PERF_CNT_EN
  logic [2:0] perf_inc;
  assign perf_inc = {bus.lookup_valid_i & ~lookup_ready, accept_miss, accept_hit};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [31:0] cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)               cnt_reg <= '0;
      else if (perf_inc[gi]) cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign bus.perf_hit_cnt_o   = g_perf[0].cnt_reg;
  assign bus.perf_miss_cnt_o  = g_perf[1].cnt_reg;
  assign bus.perf_stall_cnt_o = g_perf[2].cnt_reg;
`endif
endmodule

// File: tb/tb_cc_reorder_issue_ctrl.sv
// Self-checking bench for cc_reorder_issue_ctrl: vector table, directed corner sequences, random run against a queue-free reference model.
module tb_cc_reorder_issue_ctrl;
  localparam int AW   = 32;
  localparam int CW   = 4;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cc_reorder_issue_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  cc_reorder_issue_ctrl #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        hafull, dafull, valid, hit;
    logic [31:0] addr;
    logic        exp_ready, exp_fwren, exp_flag, exp_dwren;
    logic [5:0]  exp_off;
    logic        exp_ar;
    logic [31:0] exp_araddr;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lookup_valid_i        = 1'b0;
    bus.lookup_hit_i          = 1'b0;
    bus.lookup_addr_i         = '0;
    bus.lookup_data_i         = '0;
    bus.hit_flag_fifo_afull_i = 1'b0;
    bus.hit_data_fifo_afull_i = 1'b0;
    bus.mem_arready_i         = 1'b0;
    bus.mem_rvalid_i          = 1'b0;
    bus.mem_rready_i          = 1'b0;
    bus.mem_rlast_i           = 1'b0;
  endtask

  task automatic set_r(input logic b);
    bus.mem_rvalid_i = b;
    bus.mem_rready_i = b;
    bus.mem_rlast_i  = b;
  endtask

  task automatic lookup(input logic hit, input logic [31:0] addr);
    bus.lookup_valid_i = 1'b1;
    bus.lookup_hit_i   = hit;
    bus.lookup_addr_i  = addr;
    bus.lookup_data_i  = {16{addr}};
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Miss accepted, then AR handshake completes; leaves state idle with one more in flight.
  task automatic do_miss(input logic [31:0] addr);
    lookup(1'b0, addr);
    step();
    bus.lookup_valid_i = 1'b0;
    bus.mem_arready_i  = 1'b1;
    step();
    bus.mem_arready_i  = 1'b0;
  endtask

  task automatic retire_n(input int n);
    set_r(1'b1);
    repeat (n) step();
    set_r(1'b0);
  endtask

  // Random-phase reference model state
  logic        m_ar_pending, m_err;
  logic [31:0] m_araddr;
  int          m_cnt;
  logic        e_fwren, e_flag, e_dwren;
  logic [5:0]  e_off;
  logic [31:0] e_dlow;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fw;
    logic m_ready, acc, ret, want_ret;
    logic [31:0] a, w;
    logic [2:0] r3;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1004, 1'b1, 1'b1, 1'b1, 1'b1, 6'h04, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_123F, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1, 32'h0000_1238};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2040, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 6'h3F, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1, 32'hFFFF_FFF8};

    // Reset state while rst is held
    idle_inputs();
    step();
    chk("rst_flag_wren", bus.hit_flag_fifo_wren_o, 0);
    chk("rst_data_wren", bus.hit_data_fifo_wren_o, 0);
    chk("rst_arvalid", bus.mem_arvalid_o, 0);
    chk("rst_araddr", bus.mem_araddr_o, 0);
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_err", bus.err_o, 0);
    do_reset();

    // Vector table: each row applied from idle with nothing in flight
    for (int i = 0; i < 8; i++) begin
      bus.hit_flag_fifo_afull_i = vecs[i].hafull;
      bus.hit_data_fifo_afull_i = vecs[i].dafull;
      lookup(vecs[i].hit, vecs[i].addr);
      bus.lookup_valid_i = vecs[i].valid;
      #1;
      chk($sformatf("vec%0d_ready", i), bus.lookup_ready_o, vecs[i].exp_ready);
      step();
      bus.lookup_valid_i = 1'b0;
      bus.hit_flag_fifo_afull_i = 1'b0;
      bus.hit_data_fifo_afull_i = 1'b0;
      chk($sformatf("vec%0d_fwren", i), bus.hit_flag_fifo_wren_o, vecs[i].exp_fwren);
      if (vecs[i].exp_fwren)
        chk($sformatf("vec%0d_flag", i), bus.hit_flag_fifo_wdata_o, vecs[i].exp_flag);
      chk($sformatf("vec%0d_dwren", i), bus.hit_data_fifo_wren_o, vecs[i].exp_dwren);
      if (vecs[i].exp_dwren) begin
        chk($sformatf("vec%0d_off", i), bus.hit_data_fifo_wdata_o[517:512], vecs[i].exp_off);
        chk($sformatf("vec%0d_data", i), bus.hit_data_fifo_wdata_o[31:0], vecs[i].addr);
      end
      chk($sformatf("vec%0d_arvalid", i), bus.mem_arvalid_o, vecs[i].exp_ar);
      if (vecs[i].exp_ar) begin
        chk($sformatf("vec%0d_araddr", i), bus.mem_araddr_o, vecs[i].exp_araddr);
        bus.mem_arready_i = 1'b1;
        set_r(1'b1);
        step();
        bus.mem_arready_i = 1'b0;
        set_r(1'b0);
        chk($sformatf("vec%0d_drain", i), bus.outstanding_o, 0);
      end
    end

    // Three back-to-back hits
    do_reset();
    a = 32'h100;
    for (int i = 0; i < 3; i++) begin
      lookup(1'b1, (i == 0) ? 32'h100 : (i == 1) ? 32'h148 : 32'h1C0);
      step();
      chk($sformatf("b2b%0d_fwren", i), bus.hit_flag_fifo_wren_o, 1);
      chk($sformatf("b2b%0d_flag", i), bus.hit_flag_fifo_wdata_o, 1);
      chk($sformatf("b2b%0d_dwren", i), bus.hit_data_fifo_wren_o, 1);
      chk($sformatf("b2b%0d_off", i), bus.hit_data_fifo_wdata_o[517:512], (i == 1) ? 6'h08 : 6'h00);
      chk($sformatf("b2b%0d_arvalid", i), bus.mem_arvalid_o, 0);
    end
    bus.lookup_valid_i = 1'b0;
    step();
    chk("b2b_end_fwren", bus.hit_flag_fifo_wren_o, 0);

    // Miss with arready delayed three cycles
    lookup(1'b0, 32'h2038);
    #1;
    chk("dly_ready_pre", bus.lookup_ready_o, 1);
    step();
    bus.lookup_valid_i = 1'b0;
    chk("dly_fwren", bus.hit_flag_fifo_wren_o, 1);
    chk("dly_flag", bus.hit_flag_fifo_wdata_o, 0);
    chk("dly_dwren", bus.hit_data_fifo_wren_o, 0);
    chk("dly_arlen", bus.mem_arlen_o, 7);
    chk("dly_arsize", bus.mem_arsize_o, 3);
    chk("dly_arburst", bus.mem_arburst_o, 2'b10);
    chk("dly_outstanding", bus.outstanding_o, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dly%0d_arvalid", k), bus.mem_arvalid_o, 1);
      chk($sformatf("dly%0d_araddr", k), bus.mem_araddr_o, 32'h2038);
      chk($sformatf("dly%0d_ready", k), bus.lookup_ready_o, 0);
      if (k > 0) chk($sformatf("dly%0d_fwren", k), bus.hit_flag_fifo_wren_o, 0);
      if (k < 2) step();
    end
    bus.mem_arready_i = 1'b1;
    step();
    bus.mem_arready_i = 1'b0;
    chk("dly_arvalid_drop", bus.mem_arvalid_o, 0);
    chk("dly_ready_post", bus.lookup_ready_o, 1);
    chk("dly_fwren_once", bus.hit_flag_fifo_wren_o, 0);
    retire_n(1);
    chk("dly_drain", bus.outstanding_o, 0);

    // Five misses against a limit of four, no R traffic
    lookup(1'b0, 32'h4018);
    bus.mem_arready_i = 1'b1;
    fw = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.hit_flag_fifo_wren_o) fw++;
    end
    chk("max_flag_writes", 32'(fw), 4);
    chk("max_outstanding", bus.outstanding_o, 4);
    chk("max_ready_low", bus.lookup_ready_o, 0);
    set_r(1'b1);
    step();
    set_r(1'b0);
    chk("max_retire_cnt", bus.outstanding_o, 3);
    chk("max_no_accept", bus.hit_flag_fifo_wren_o, 0);
    #1;
    chk("max_ready_again", bus.lookup_ready_o, 1);
    step();
    bus.lookup_valid_i = 1'b0;
    chk("max_fifth_fwren", bus.hit_flag_fifo_wren_o, 1);
    chk("max_fifth_cnt", bus.outstanding_o, 4);
    step();
    bus.mem_arready_i = 1'b0;
    retire_n(4);
    chk("max_drain", bus.outstanding_o, 0);

    // Miss accept and retire in the same cycle
    do_miss(32'h5000);
    do_miss(32'h5040);
    chk("same_pre", bus.outstanding_o, 2);
    lookup(1'b0, 32'h5080);
    set_r(1'b1);
    step();
    bus.lookup_valid_i = 1'b0;
    set_r(1'b0);
    chk("same_cnt", bus.outstanding_o, 2);
    chk("same_fwren", bus.hit_flag_fifo_wren_o, 1);
    bus.mem_arready_i = 1'b1;
    step();
    bus.mem_arready_i = 1'b0;
    retire_n(2);
    chk("same_drain", bus.outstanding_o, 0);

    // Data FIFO almost full holds off a pending hit
    bus.hit_data_fifo_afull_i = 1'b1;
    lookup(1'b1, 32'h0000_0516);
    #1;
    chk("afull_ready", bus.lookup_ready_o, 0);
    step();
    chk("afull_fwren", bus.hit_flag_fifo_wren_o, 0);
    chk("afull_dwren", bus.hit_data_fifo_wren_o, 0);
    bus.hit_data_fifo_afull_i = 1'b0;
    #1;
    chk("afull_ready_rel", bus.lookup_ready_o, 1);
    step();
    bus.lookup_valid_i = 1'b0;
    chk("afull_acc_fwren", bus.hit_flag_fifo_wren_o, 1);
    chk("afull_acc_dwren", bus.hit_data_fifo_wren_o, 1);
    chk("afull_acc_off", bus.hit_data_fifo_wdata_o[517:512], 6'h16);

    // Retire with nothing in flight, then reset in the middle of AR_WAIT
    retire_n(1);
    chk("err_set", bus.err_o, 1);
    chk("err_cnt_zero", bus.outstanding_o, 0);
    step();
    step();
    chk("err_sticky", bus.err_o, 1);
    lookup(1'b0, 32'h6000);
    step();
    bus.lookup_valid_i = 1'b0;
    step();
    chk("mid_arvalid", bus.mem_arvalid_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_arvalid", bus.mem_arvalid_o, 0);
    chk("mid_rst_cnt", bus.outstanding_o, 0);
    chk("mid_rst_err", bus.err_o, 0);
    step();
    rst = 1'b0;
    #1;

    // Random traffic against the reference model
    m_ar_pending = 1'b0; m_err = 1'b0; m_araddr = '0; m_cnt = 0;
    e_fwren = 1'b0; e_flag = 1'b0; e_dwren = 1'b0; e_off = '0; e_dlow = '0;
    for (int c = 0; c < 1500; c++) begin
      chk("rnd_fwren", bus.hit_flag_fifo_wren_o, e_fwren);
      if (e_fwren) chk("rnd_flag", bus.hit_flag_fifo_wdata_o, e_flag);
      chk("rnd_dwren", bus.hit_data_fifo_wren_o, e_dwren);
      if (e_dwren) begin
        chk("rnd_off", bus.hit_data_fifo_wdata_o[517:512], e_off);
        chk("rnd_data", bus.hit_data_fifo_wdata_o[511:480], e_dlow);
      end
      chk("rnd_arvalid", bus.mem_arvalid_o, m_ar_pending);
      if (m_ar_pending) chk("rnd_araddr", bus.mem_araddr_o, m_araddr);
      chk("rnd_cnt", bus.outstanding_o, 32'(m_cnt));
      chk("rnd_err", bus.err_o, m_err);

      a = $urandom;
      w = $urandom;
      bus.lookup_valid_i        = ($urandom_range(0, 3) != 0);
      bus.lookup_hit_i          = $urandom_range(0, 1) == 1;
      bus.lookup_addr_i         = a;
      bus.lookup_data_i         = {16{w}};
      bus.hit_flag_fifo_afull_i = ($urandom_range(0, 7) == 0);
      bus.hit_data_fifo_afull_i = ($urandom_range(0, 7) == 0);
      bus.mem_arready_i         = ($urandom_range(0, 2) == 0);
      want_ret = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
      r3 = want_ret ? 3'b111 : 3'($urandom_range(0, 6));
      {bus.mem_rvalid_i, bus.mem_rready_i, bus.mem_rlast_i} = r3;
      #1;

      m_ready = !m_ar_pending && !bus.hit_flag_fifo_afull_i && !bus.hit_data_fifo_afull_i && (m_cnt < MAXO);
      chk("rnd_ready", bus.lookup_ready_o, m_ready);
      acc = bus.lookup_valid_i && m_ready;
      ret = (r3 == 3'b111);

      e_fwren = acc;
      e_flag  = bus.lookup_hit_i;
      e_dwren = acc && bus.lookup_hit_i;
      e_off   = a[5:0];
      e_dlow  = w;
      if (m_ar_pending && bus.mem_arready_i) m_ar_pending = 1'b0;
      if (acc && !bus.lookup_hit_i) begin
        m_ar_pending = 1'b1;
        m_araddr     = a & 32'hFFFF_FFF8;
      end
      if (ret && m_cnt == 0) m_err = 1'b1;
      m_cnt = m_cnt + ((acc && !bus.lookup_hit_i) ? 1 : 0) - (ret ? 1 : 0);
      if (m_cnt < 0) m_cnt = 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cc_reorder_issue_ctrl.md
Name: cc_reorder_issue_ctrl

Overview:
- Issue sequencer in front of the cache-controller data reorder unit.
- Accepts tag-lookup results in order and writes one ordering flag per request into the hit-flag FIFO.
- Hits: pushes {offset, line data} into the hit-data FIFO.
- Misses: issues an AXI AR wrap burst to memory and tracks outstanding misses by watching R-channel last beats, so the reorder unit always sees flags in the same order as the responses.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight miss bursts; range 1..15.
ADDR_WIDTH, 32, lookup and AR address width.
CNT_WIDTH, 4, outstanding counter width; must satisfy 2^CNT_WIDTH > MAX_OUTSTANDING.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
lookup_valid_i  in  1  lookup result valid
lookup_ready_o  out  1  lookup result accepted when high with valid
lookup_hit_i  in  1  1 = hit, 0 = miss
lookup_addr_i  in  ADDR_WIDTH  request byte address
lookup_data_i  in  512  hit line data (ignored on miss)
hit_flag_fifo_afull_i  in  1  flag FIFO almost full
hit_flag_fifo_wren_o  out  1  flag FIFO write
hit_flag_fifo_wdata_o  out  1  flag; 1 = hit
hit_data_fifo_afull_i  in  1  data FIFO almost full
hit_data_fifo_wren_o  out  1  data FIFO write
hit_data_fifo_wdata_o  out  518  {addr[5:0], line[511:0]}
mem_arvalid_o  out  1  AR valid
mem_arready_i  in  1  AR ready
mem_araddr_o  out  ADDR_WIDTH  AR address
mem_arlen_o  out  4  burst length; constant 7
mem_arsize_o  out  3  burst size; constant 3 (8 B)
mem_arburst_o  out  2  burst type; constant 2'b10 (WRAP)
mem_rvalid_i  in  1  observed R valid
mem_rready_i  in  1  observed R ready (from reorder unit)
mem_rlast_i  in  1  observed R last
outstanding_o  out  CNT_WIDTH  in-flight miss count
err_o  out  1  sticky: rlast seen with zero outstanding

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including outstanding_o and err_o. AR is dropped immediately, even mid-handshake.
- FSM has two states: IDLE and AR_WAIT.
- lookup_ready_o = (state==IDLE) & !hit_flag_fifo_afull_i & !hit_data_fifo_afull_i & (outstanding_o < MAX_OUTSTANDING).
  - It depends only on registered state and the afull inputs, never on lookup_valid_i.
- Accept = lookup_valid_i & lookup_ready_o.
- Accepted hit:
  - Next cycle: single-cycle pulse on hit_flag_fifo_wren_o with wdata=1.
  - Same cycle: single-cycle pulse on hit_data_fifo_wren_o with wdata={addr[5:0], data}.
  - State stays IDLE; back-to-back hits run 1 per cycle.
- Accepted miss:
  - Next cycle: hit_flag_fifo_wren_o pulses with wdata=0.
  - Same cycle: mem_arvalid_o=1, mem_araddr_o={addr[AW-1:3], 3'b000} (critical word first).
  - State goes to AR_WAIT; outstanding increments on the accept edge.
- AR_WAIT:
  - arvalid and araddr are held stable until mem_arready_i.
  - On the handshake cycle: arvalid drops next cycle and state returns to IDLE.
  - No new lookup is accepted while in AR_WAIT.
- Last-beat retire = mem_rvalid_i & mem_rready_i & mem_rlast_i; outstanding decrements.
  - Miss accept and retire in the same cycle: count unchanged.
  - Retire with count 0: count stays 0 and err_o is set. err_o clears only on reset.
- Afull thresholds leave at least 2 free entries, so the one-cycle write latency cannot overflow either FIFO.
- Flag write order always equals accept order.

Optional Feature:
- Macro CC_ISSUE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_hit_cnt_o[31:0] and perf_miss_cnt_o[31:0]. They increment on accepted hit and accepted miss respectively, wrap at 2^32, and reset to 0.
  - Adds perf_stall_cnt_o[31:0], counting cycles with lookup_valid_i=1 and lookup_ready_o=0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then 3 hits back-to-back, addr 0x100/0x148/0x1C0 -> 3 consecutive flag writes of 1; data wdata[517:512] = 0x00/0x08/0x00; no arvalid.
- Miss at 0x2038, arready delayed 3 cycles -> araddr=0x2038 held stable, arlen=7, arburst=2'b10; flag 0 written once; outstanding=1; lookup_ready_o low until the cycle after the handshake.
- MAX_OUTSTANDING=4, 5 misses with no R traffic -> 5th not accepted, ready stays low; one rlast beat -> outstanding 4->3, 5th accepted.
- Miss accept and rlast retire in the same cycle with outstanding=2 -> outstanding stays 2.
- hit_data_fifo_afull_i=1 with valid hit pending -> no accept, no writes; deassert -> accept next cycle.
- rlast beat with outstanding=0 -> err_o=1 and sticky; rst pulse mid-AR_WAIT -> arvalid=0 at once, outstanding=0, err_o=0.
